// File: rtl/dled_pkg.sv
// Shared constants and types for the DLED seven-segment scan controller.
package dled_pkg;

  localparam int unsigned NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low g..a patterns for 0..F, entry 0 at the least significant byte; bit 7 (dp) reads as off.
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    ST_BLANK,
    ST_ON,
    ST_OFF
  } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble plus decimal-point request to an active-low segment pattern.
module seg7_decode
  import dled_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp_on,
  output logic [7:0] o_seg_c
);

  always_comb begin
    o_seg_c    = SEG_HEX[i_nibble];
    o_seg_c[7] = ~i_dp_on;
  end

endmodule

// File: rtl/dled_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scanner with ghost blanking, PWM dimming
// and frame-aligned shadowing of the display inputs.
module dled_scan_ctrl
  import dled_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 50000,
  parameter int unsigned BLANK_TICKS = 64,
  parameter int unsigned NUM_DIGITS  = dled_pkg::NUM_DIGITS
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [4*NUM_DIGITS-1:0]   dled_value,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic [3:0]                brightness,
  input  logic                      update,
  output logic [7:0]                SEG,
  output logic [NUM_DIGITS-1:0]     AN,
  output logic                      frame_done
);

  localparam int unsigned STEP  = (DIGIT_TICKS - BLANK_TICKS) / 16;
  localparam int unsigned CNT_W = $clog2(DIGIT_TICKS);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_TICKS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_idx;
  scan_state_e               r_state;
  logic                      r_pending;
  logic [4*NUM_DIGITS-1:0]   r_value_sh;
  logic [NUM_DIGITS-1:0]     r_en_sh;
  logic [NUM_DIGITS-1:0]     r_dp_sh;
  logic [3:0]                r_bri_sh;

  logic                      w_cnt_wrap;
  logic                      w_frame_end;
  logic [CNT_W-1:0]          w_cnt_next;
  logic [CNT_W-1:0]          w_on_end;
  scan_state_e               w_state_next;
  logic                      w_lit;
  logic [3:0]                w_nibble;
  logic                      w_dp_on;
  logic [NUM_DIGITS-1:0]     w_an_on;
  logic [7:0]                w_seg;

  // Slot timing: the state always describes the counter value it is registered with.
  always_comb begin
    w_cnt_wrap   = (r_cnt == CNT_LAST);
    w_frame_end  = w_cnt_wrap && (r_idx == IDX_LAST);
    w_cnt_next   = w_cnt_wrap ? '0 : r_cnt + CNT_W'(1);
    w_on_end     = CNT_W'(BLANK_TICKS + 32'(r_bri_sh) * STEP);
    w_state_next = ST_OFF;
    if (w_cnt_wrap || (w_cnt_next < CNT_BLANK)) begin
      w_state_next = ST_BLANK;
    end else if (w_cnt_next < w_on_end) begin
      w_state_next = ST_ON;
    end
  end

  // Current digit selection; disabled digits consume their slot but stay dark.
  always_comb begin
    w_lit    = (r_state == ST_ON) && r_en_sh[r_idx];
    w_nibble = r_value_sh[{r_idx, 2'b00} +: 4];
    w_dp_on  = r_dp_sh[r_idx];
    w_an_on  = ~(NUM_DIGITS'(1) << r_idx);
  end

  seg7_decode u_seg7_decode (
    .i_nibble (w_nibble),
    .i_dp_on  (w_dp_on),
    .o_seg_c  (w_seg)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_state    <= ST_BLANK;
      r_pending  <= 1'b0;
      r_value_sh <= '0;
      r_en_sh    <= '0;
      r_dp_sh    <= '0;
      r_bri_sh   <= '0;
      SEG        <= SEG_BLANK;
      AN         <= '1;
      frame_done <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_state    <= w_state_next;
      frame_done <= w_frame_end;
      if (w_cnt_wrap) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
      // An update landing in the boundary cycle is honoured at that same boundary.
      if (w_frame_end) begin
        if (r_pending || update) begin
          r_value_sh <= dled_value;
          r_en_sh    <= digit_en;
          r_dp_sh    <= dp;
          r_bri_sh   <= brightness;
        end
        r_pending <= 1'b0;
      end else if (update) begin
        r_pending <= 1'b1;
      end
      SEG <= w_lit ? w_seg : SEG_BLANK;
      AN  <= w_lit ? w_an_on : '1;
    end
  end

endmodule
